sd_req_arb: RTL and testbench
=============================

SD_REQ_ARB -- requirements
Module: sd_req_arb

Interface
REQ-001 Parameter VDNUM, default 4, number of virtual-disk requesters (legal 1..4); VD = VDNUM-1.
REQ-002 Parameter TIMEOUT, default 1048575, max clk_sys cycles in ISSUE before abort (20-bit counter).
REQ-003 clk_sys  in  1  single clock; all logic on rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 req_rd  in  VDNUM  per-requester read request, level, held until req_done.
REQ-006 req_wr  in  VDNUM  per-requester write request, level, held until req_done.
REQ-007 req_lba  in  32*VDNUM  per-requester LBA; slice i = bits [32i+31:32i].
REQ-008 req_buff_din  in  8*VDNUM  per-requester write-buffer read data.
REQ-009 req_ack  out  VDNUM  one-hot; bit i = sd_ack while i granted.
REQ-010 req_done  out  VDNUM  one-cycle pulse on completion or abort of requester i.
REQ-011 req_err  out  VDNUM  one-cycle pulse with req_done when the transfer aborted on timeout.
REQ-012 req_buff_wr  out  VDNUM  bit i = sd_buff_wr while i granted, else 0.
REQ-013 sd_lba  out  32  LBA to host I/O bridge.
REQ-014 sd_rd / sd_wr  out  VDNUM each  to bridge; at most one bit of the 2*VDNUM set.
REQ-015 sd_ack  in  1  from bridge; high for the whole sector transfer.
REQ-016 sd_buff_wr  in  1  from bridge; buffer write strobe.
REQ-017 sd_buff_din  out  8  slice of req_buff_din for granted requester, 0 when none.

Function
REQ-018 States IDLE, ISSUE, XFER, DONE; 2-bit grant index g, 2-bit round-robin pointer p, op flag (0 = rd, 1 = wr).
REQ-019 IDLE: pending = req_rd|req_wr; if nonzero, grant the first pending index scanning p, p+1, ... modulo VDNUM; next state ISSUE.
REQ-020 On grant: g latched, sd_lba <= req_lba[g] (registered, stable until DONE), op <= 0 if req_rd[g] else 1 (rd wins when both set).
REQ-021 ISSUE: sd_rd[g] = ~op, sd_wr[g] = op, all other bits 0; timeout counter increments each cycle.
REQ-022 ISSUE -> XFER on first cycle sd_ack = 1; sd_rd/sd_wr drop to 0 in the same transition (registered, visible next cycle).
REQ-023 ISSUE -> DONE with req_err[g] if counter reaches TIMEOUT; sd_rd/sd_wr cleared.
REQ-024 ISSUE -> IDLE with no req_done if requester g drops both req_rd and req_wr before sd_ack; sd_rd/sd_wr cleared.
REQ-025 XFER: remain while sd_ack = 1; on sd_ack falling -> DONE. Dropping req_rd/req_wr in XFER is ignored.
REQ-026 DONE: one cycle; req_done[g] = 1; p <= g+1 modulo VDNUM; next IDLE. Minimum gap between two grants = 1 IDLE cycle.
REQ-027 req_ack, req_buff_wr, sd_buff_din are combinational from g and state (valid in ISSUE/XFER only); zero elsewhere.
REQ-028 Requester bits with index >= VDNUM do not exist; VDNUM = 1 degenerates to pass-through with same FSM.
REQ-029 Requests rising during XFER/DONE are held until IDLE; no request is lost or duplicated.

Reset
REQ-030 reset_n = 0 at a clock edge: state IDLE, g = 0, p = 0, op = 0, counter = 0, sd_lba = 0, sd_rd = sd_wr = 0, req_done = req_err = 0; mid-transfer reset aborts without req_done.
REQ-031 Combinational outputs (req_ack, req_buff_wr, sd_buff_din) read 0 while in reset.

Verification
REQ-032 Single read: req_rd[1] = 1, req_lba[1] = 0x1234 -> next cycle sd_rd = 0b0010, sd_lba = 0x1234; sd_ack 512 cycles -> req_ack[1] mirrors, req_done[1] pulses 1 cycle after sd_ack falls.
REQ-033 Round-robin: req_rd[0], req_wr[2], req_rd[3] all held from reset -> grants in order 0, 2, 3; then re-assert 0 and 3 -> grant 3 before 0 is wrong, expect 0 then 3 (p = 0 after wrap).
REQ-034 Rd/wr collision: req_rd[2] = req_wr[2] = 1 -> sd_rd = 0b0100, sd_wr = 0; never both driven.
REQ-035 Timeout: TIMEOUT = 16, req_wr[0] with sd_ack never high -> sd_wr[0] high 16 cycles, then req_done[0] and req_err[0] pulse together.
REQ-036 Buffer routing: grant 1 in XFER, sd_buff_wr pulses -> only req_buff_wr[1] pulses; req_buff_din[15:8] = 0xA5 -> sd_buff_din = 0xA5.
REQ-037 Reset mid-XFER: reset_n low for 1 cycle -> all outputs 0, state IDLE, no req_done; pending request re-granted from index 0.

Source files
------------

// File: rtl/sd_req_arb.sv
// ---------------------------------------------------------------------------
// sd_req_arb
//   Round-robin arbiter that lets up to four virtual-disk requesters share one
//   sector-level host I/O bridge. A request is granted in IDLE. Its LBA and
//   direction are latched, and the matching sd_rd/sd_wr bit is raised until
//   the bridge acknowledges. The bridge's ack and buffer signals are then
//   routed to the granted requester, and completion is signalled with a
//   one-cycle req_done. req_err also pulses if the bridge never answered.
//
// Ports
//   clk_sys       in   single clock, rising edge
//   reset_n       in   synchronous active-low reset
//   req_rd/wr     in   [VDNUM]     level requests, held until req_done
//   req_lba       in   [32*VDNUM]  per-requester LBA
//   req_buff_din  in   [8*VDNUM]   per-requester write-buffer data
//   req_ack       out  [VDNUM]     sd_ack routed to the granted requester
//   req_done      out  [VDNUM]     completion / abort pulse
//   req_err       out  [VDNUM]     timeout pulse, coincident with req_done
//   req_buff_wr   out  [VDNUM]     sd_buff_wr routed to the granted requester
//   sd_lba        out  [32]        latched LBA of the granted request
//   sd_rd/sd_wr   out  [VDNUM]     command to bridge, at most one bit set
//   sd_ack        in   bridge busy with the sector transfer
//   sd_buff_wr    in   bridge buffer write strobe
//   sd_buff_din   out  [8]         buffer data of the granted requester
// ---------------------------------------------------------------------------
module sd_req_arb #(
   parameter int VDNUM   = 4,
   parameter int TIMEOUT = 1048575
) (
   input  logic                  clk_sys,
   input  logic                  reset_n,
   input  logic [VDNUM-1:0]      req_rd,
   input  logic [VDNUM-1:0]      req_wr,
   input  logic [32*VDNUM-1:0]   req_lba,
   input  logic [8*VDNUM-1:0]    req_buff_din,
   output logic [VDNUM-1:0]      req_ack,
   output logic [VDNUM-1:0]      req_done,
   output logic [VDNUM-1:0]      req_err,
   output logic [VDNUM-1:0]      req_buff_wr,
   output logic [31:0]           sd_lba,
   output logic [VDNUM-1:0]      sd_rd,
   output logic [VDNUM-1:0]      sd_wr,
   input  logic                  sd_ack,
   input  logic                  sd_buff_wr,
   output logic [7:0]            sd_buff_din
);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_XFER, ST_DONE} state_t;

   // Last ISSUE cycle count before giving up on the bridge.
   localparam logic [19:0] TO_LAST = 20'(TIMEOUT - 1);

   state_t             state_reg, state_next;
   logic [1:0]         g_reg, g_next;
   logic [1:0]         p_reg, p_next;
   logic               op_reg, op_next;
   logic [19:0]        cnt_reg, cnt_next;
   logic [31:0]        lba_reg, lba_next;
   logic [VDNUM-1:0]   sd_rd_reg, sd_rd_next;
   logic [VDNUM-1:0]   sd_wr_reg, sd_wr_next;
   logic [VDNUM-1:0]   done_reg, done_next;
   logic [VDNUM-1:0]   err_reg, err_next;

   logic [31:0]        lba_arr  [VDNUM];
   logic [7:0]         din_arr  [VDNUM];
   logic [1:0]         scan_idx [VDNUM];
   logic [VDNUM-1:0]   pending;
   logic               found;
   logic [1:0]         pick;
   logic               active;

   // Unpack per-requester buses and build the rotated scan order p, p+1, ...
   for (genvar gi = 0; gi < VDNUM; gi++) begin : g_req
      logic [2:0] sum;
      assign lba_arr[gi]  = req_lba[32*gi +: 32];
      assign din_arr[gi]  = req_buff_din[8*gi +: 8];
      assign sum          = {1'b0, p_reg} + 3'(gi);
      assign scan_idx[gi] = (sum >= 3'(VDNUM)) ? 2'(sum - 3'(VDNUM)) : sum[1:0];
   end

   assign pending = req_rd | req_wr;

   // First pending requester in rotated order.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int k = 0; k < VDNUM; k++) begin
         if (!found && pending[scan_idx[k]]) begin
            found = 1'b1;
            pick  = scan_idx[k];
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state_reg <= ST_IDLE;
         g_reg     <= '0;
         p_reg     <= '0;
         op_reg    <= 1'b0;
         cnt_reg   <= '0;
         lba_reg   <= '0;
         sd_rd_reg <= '0;
         sd_wr_reg <= '0;
         done_reg  <= '0;
         err_reg   <= '0;
      end else begin
         state_reg <= state_next;
         g_reg     <= g_next;
         p_reg     <= p_next;
         op_reg    <= op_next;
         cnt_reg   <= cnt_next;
         lba_reg   <= lba_next;
         sd_rd_reg <= sd_rd_next;
         sd_wr_reg <= sd_wr_next;
         done_reg  <= done_next;
         err_reg   <= err_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      g_next     = g_reg;
      p_next     = p_reg;
      op_next    = op_reg;
      cnt_next   = cnt_reg;
      lba_next   = lba_reg;
      sd_rd_next = sd_rd_reg;
      sd_wr_next = sd_wr_reg;
      done_next  = '0;
      err_next   = '0;
      case (state_reg)
         ST_IDLE: begin
            cnt_next   = '0;
            sd_rd_next = '0;
            sd_wr_next = '0;
            if (found) begin
               state_next       = ST_ISSUE;
               g_next           = pick;
               lba_next         = lba_arr[pick];
               // Read wins when a requester raises both lines.
               op_next          = ~req_rd[pick];
               sd_rd_next[pick] = req_rd[pick];
               sd_wr_next[pick] = ~req_rd[pick];
            end
         end
         ST_ISSUE: begin
            sd_rd_next = '0;
            sd_wr_next = '0;
            if (sd_ack) begin
               state_next = ST_XFER;
            end else if (!(req_rd[g_reg] | req_wr[g_reg])) begin
               // Requester withdrew before the bridge picked it up: silent abort.
               state_next = ST_IDLE;
            end else if (cnt_reg == TO_LAST) begin
               state_next       = ST_DONE;
               done_next[g_reg] = 1'b1;
               err_next[g_reg]  = 1'b1;
            end else begin
               cnt_next          = cnt_reg + 20'd1;
               sd_rd_next[g_reg] = ~op_reg;
               sd_wr_next[g_reg] = op_reg;
            end
         end
         ST_XFER: begin
            if (!sd_ack) begin
               state_next       = ST_DONE;
               done_next[g_reg] = 1'b1;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
            p_next     = (g_reg == 2'(VDNUM - 1)) ? 2'd0 : g_reg + 2'd1;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Routing is live only while a grant is outstanding and never during reset.
   assign active = reset_n && ((state_reg == ST_ISSUE) || (state_reg == ST_XFER));

   for (genvar gi = 0; gi < VDNUM; gi++) begin : g_route
      assign req_ack[gi]     = active && (g_reg == 2'(gi)) && sd_ack;
      assign req_buff_wr[gi] = active && (g_reg == 2'(gi)) && sd_buff_wr;
   end

   assign sd_buff_din = active ? din_arr[g_reg] : 8'd0;
   assign sd_lba      = lba_reg;
   assign sd_rd       = sd_rd_reg;
   assign sd_wr       = sd_wr_reg;
   assign req_done    = done_reg;
   assign req_err     = err_reg;

endmodule

// File: tb/tb_sd_req_arb.sv
// ---------------------------------------------------------------------------
// tb_sd_req_arb
//   Self-checking bench for sd_req_arb (VDNUM = 4, TIMEOUT = 16).
//   Inputs are driven and outputs sampled on the falling edge. A table of
//   single-grant vectors comes first, then hand sequences for the multi-cycle
//   corners, then randomized traffic checked against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_sd_req_arb;

   localparam int VDNUM = 4;
   localparam int TOUT  = 16;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [3:0]    req_rd, req_wr;
   logic [127:0]  req_lba;
   logic [31:0]   req_buff_din;
   logic [3:0]    req_ack, req_done, req_err, req_buff_wr;
   logic [31:0]   sd_lba;
   logic [3:0]    sd_rd, sd_wr;
   logic          sd_ack, sd_buff_wr;
   logic [7:0]    sd_buff_din;

   int vec_cnt = 0;
   int err_cnt = 0;

   sd_req_arb #(.VDNUM(VDNUM), .TIMEOUT(TOUT)) dut (
      .clk_sys      (clk),
      .reset_n      (reset_n),
      .req_rd       (req_rd),
      .req_wr       (req_wr),
      .req_lba      (req_lba),
      .req_buff_din (req_buff_din),
      .req_ack      (req_ack),
      .req_done     (req_done),
      .req_err      (req_err),
      .req_buff_wr  (req_buff_wr),
      .sd_lba       (sd_lba),
      .sd_rd        (sd_rd),
      .sd_wr        (sd_wr),
      .sd_ack       (sd_ack),
      .sd_buff_wr   (sd_buff_wr),
      .sd_buff_din  (sd_buff_din)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  rd;
      logic [3:0]  wr;
      logic [3:0]  exp_rd;
      logic [3:0]  exp_wr;
      logic [31:0] exp_lba;
   } vec_t;

   vec_t tbl[8];

   function automatic logic [3:0] oh(input int i);
      return 4'b0001 << i;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_lba(input int i, input logic [31:0] v);
      req_lba[32*i +: 32] = v;
   endtask

   task automatic do_reset();
      reset_n      = 1'b0;
      req_rd       = '0;
      req_wr       = '0;
      sd_ack       = 1'b0;
      sd_buff_wr   = 1'b0;
      step();
      reset_n      = 1'b1;
   endtask

   // Current obs shows a command for idx; run a transfer of len ack cycles,
   // check completion, drop the request and advance to the next grant slot.
   task automatic complete_xfer(input int idx, input int len);
      sd_ack = 1'b1;
      repeat (len) step();
      sd_ack = 1'b0;
      step();
      chk($sformatf("cx_done%0d", idx), req_done, oh(idx));
      chk($sformatf("cx_err%0d", idx), req_err, 4'b0000);
      req_rd[idx] = 1'b0;
      req_wr[idx] = 1'b0;
      step();
      chk($sformatf("cx_pulse%0d", idx), req_done, 4'b0000);
      step();
   endtask

   // Random-phase model state
   logic        m_busy, m_to, m_idle_prev, m_exp_done, m_is_wr;
   int          m_g, m_ptr, m_c, m_d, m_len, m_issue_end, m_done_at, m_r;
   logic [31:0] m_lba;
   logic [3:0]  pend_a, rd_a, exp_vec;
   logic        ack_a, bwr_a;
   logic [31:0] din_a;

   initial begin
      reset_n = 1'b0; req_rd = '0; req_wr = '0; req_lba = '0;
      req_buff_din = '0; sd_ack = 1'b0; sd_buff_wr = 1'b0;

      // ---------------- reset state ----------------
      sd_ack = 1'b1; sd_buff_wr = 1'b1;
      step();
      chk("rst_sd_rd",   sd_rd,       4'b0);
      chk("rst_sd_wr",   sd_wr,       4'b0);
      chk("rst_done",    req_done,    4'b0);
      chk("rst_err",     req_err,     4'b0);
      chk("rst_lba",     sd_lba,      32'h0);
      chk("rst_ack",     req_ack,     4'b0);
      chk("rst_bwr",     req_buff_wr, 4'b0);
      chk("rst_bdin",    sd_buff_din, 8'h0);

      // ---------------- table-driven single grants from reset ----------------
      tbl[0] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 32'h1000_0000};
      tbl[1] = '{4'b0000, 4'b0100, 4'b0000, 4'b0100, 32'h1202_0202};
      tbl[2] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 32'h1202_0202};
      tbl[3] = '{4'b1000, 4'b0010, 4'b0000, 4'b0010, 32'h1101_0101};
      tbl[4] = '{4'b1100, 4'b0000, 4'b0100, 4'b0000, 32'h1202_0202};
      tbl[5] = '{4'b0000, 4'b1000, 4'b0000, 4'b1000, 32'h1303_0303};
      tbl[6] = '{4'b1010, 4'b0101, 4'b0000, 4'b0001, 32'h1000_0000};
      tbl[7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0000_0000};
      for (int i = 0; i < 4; i++) set_lba(i, 32'h1000_0000 + 32'h0101_0101 * i);
      for (int v = 0; v < 8; v++) begin
         do_reset();
         req_rd = tbl[v].rd;
         req_wr = tbl[v].wr;
         step();
         chk($sformatf("tbl%0d_sd_rd", v), sd_rd, tbl[v].exp_rd);
         chk($sformatf("tbl%0d_sd_wr", v), sd_wr, tbl[v].exp_wr);
         chk($sformatf("tbl%0d_lba", v),   sd_lba, tbl[v].exp_lba);
         step();
         chk($sformatf("tbl%0d_hold_rd", v), sd_rd, tbl[v].exp_rd);
         chk($sformatf("tbl%0d_hold_wr", v), sd_wr, tbl[v].exp_wr);
         chk($sformatf("tbl%0d_done", v),    req_done, 4'b0);
      end

      // ---------------- single read, 512-cycle sector ----------------
      do_reset();
      set_lba(1, 32'h0000_1234);
      req_rd[1] = 1'b1;
      step();
      chk("rd1_sd_rd", sd_rd, 4'b0010);
      chk("rd1_lba",   sd_lba, 32'h1234);
      chk("rd1_ack0",  req_ack, 4'b0);
      sd_ack = 1'b1;
      for (int k = 0; k < 512; k++) begin
         step();
         chk("rd1_ack", req_ack, 4'b0010);
         if (k == 0) chk("rd1_sd_rd_drop", sd_rd, 4'b0);
      end
      chk("rd1_nodone", req_done, 4'b0);
      sd_ack = 1'b0;
      step();
      chk("rd1_done", req_done, 4'b0010);
      req_rd[1] = 1'b0;
      step();
      chk("rd1_pulse", req_done, 4'b0);

      // ---------------- round robin 0,2,3 then 0,3 ----------------
      do_reset();
      req_rd[0] = 1'b1; req_wr[2] = 1'b1; req_rd[3] = 1'b1;
      step();
      chk("rr_g0", sd_rd, 4'b0001);
      complete_xfer(0, 3);
      chk("rr_g2", sd_wr, 4'b0100);
      chk("rr_g2_rd", sd_rd, 4'b0000);
      complete_xfer(2, 2);
      chk("rr_g3", sd_rd, 4'b1000);
      complete_xfer(3, 1);
      chk("rr_idle", {sd_rd, sd_wr}, 8'h00);
      req_rd[0] = 1'b1; req_rd[3] = 1'b1;
      step();
      chk("rr_wrap_g0", sd_rd, 4'b0001);
      complete_xfer(0, 2);
      chk("rr_wrap_g3", sd_rd, 4'b1000);
      complete_xfer(3, 2);

      // ---------------- timeout ----------------
      do_reset();
      req_wr[0] = 1'b1;
      step();
      for (int k = 0; k < TOUT; k++) begin
         chk("to_sd_wr", sd_wr, 4'b0001);
         chk("to_nodone", req_done, 4'b0);
         step();
      end
      chk("to_sd_wr_clr", sd_wr, 4'b0);
      chk("to_done", req_done, 4'b0001);
      chk("to_err",  req_err,  4'b0001);
      req_wr[0] = 1'b0;
      step();
      chk("to_done_pulse", req_done, 4'b0);
      chk("to_err_pulse",  req_err,  4'b0);

      // ---------------- buffer routing ----------------
      do_reset();
      req_buff_din = 32'h33_22_A5_11;
      req_rd[1] = 1'b1;
      step();
      sd_ack = 1'b1;
      step();
      chk("buf_din", sd_buff_din, 8'hA5);
      chk("buf_bwr0", req_buff_wr, 4'b0);
      sd_buff_wr = 1'b1;
      step();
      chk("buf_bwr1", req_buff_wr, 4'b0010);
      sd_buff_wr = 1'b0;
      step();
      chk("buf_bwr_off", req_buff_wr, 4'b0);
      sd_ack = 1'b0;
      step();
      chk("buf_done", req_done, 4'b0010);
      chk("buf_din_idle", sd_buff_din, 8'h00);
      req_rd[1] = 1'b0;
      step();

      // ---------------- withdraw during ISSUE ----------------
      do_reset();
      req_wr[3] = 1'b1;
      step();
      chk("wd_sd_wr", sd_wr, 4'b1000);
      req_wr[3] = 1'b0;
      step();
      chk("wd_clr", sd_wr, 4'b0);
      chk("wd_nodone", req_done, 4'b0);
      step();
      chk("wd_nodone2", req_done, 4'b0);

      // ---------------- reset mid-XFER ----------------
      do_reset();
      req_rd[0] = 1'b1;
      step();
      chk("rx_g0", sd_rd, 4'b0001);
      complete_xfer(0, 2);
      req_rd[0] = 1'b1; req_rd[2] = 1'b1;
      step();
      chk("rx_g2", sd_rd, 4'b0100);
      sd_ack = 1'b1;
      step();
      chk("rx_ack", req_ack, 4'b0100);
      reset_n = 1'b0;
      #1;
      chk("rx_ack_in_rst", req_ack, 4'b0);
      step();
      chk("rx_sd_rd", sd_rd, 4'b0);
      chk("rx_sd_wr", sd_wr, 4'b0);
      chk("rx_done",  req_done, 4'b0);
      chk("rx_err",   req_err, 4'b0);
      chk("rx_lba",   sd_lba, 32'h0);
      chk("rx_ack_r", req_ack, 4'b0);
      reset_n = 1'b1;
      sd_ack  = 1'b0;
      step();
      chk("rx_regrant0", sd_rd, 4'b0001);
      chk("rx_nodone",   req_done, 4'b0);

      // ---------------- randomized traffic vs model ----------------
      do_reset();
      req_buff_din = '0;
      m_busy = 1'b0; m_to = 1'b0; m_idle_prev = 1'b0; m_is_wr = 1'b0;
      m_g = 0; m_ptr = 0; m_c = 0; m_d = 0; m_len = 0; m_issue_end = 0; m_done_at = 0;
      m_lba = '0;
      for (int t = 0; t < 3000; t++) begin
         pend_a = req_rd | req_wr;
         rd_a   = req_rd;
         ack_a  = sd_ack;
         bwr_a  = sd_buff_wr;
         din_a  = req_buff_din;

         m_exp_done = m_busy && (t == m_done_at);
         chk("rnd_done", req_done, m_exp_done ? oh(m_g) : 4'b0);
         chk("rnd_err",  req_err, (m_exp_done && m_to) ? oh(m_g) : 4'b0);
         if (m_exp_done) begin
            m_busy = 1'b0;
            m_ptr  = (m_g + 1) % VDNUM;
         end

         if (m_idle_prev && pend_a != 4'b0) begin
            for (int k = VDNUM - 1; k >= 0; k--)
               if (pend_a[(m_ptr + k) % VDNUM]) m_g = (m_ptr + k) % VDNUM;
            m_is_wr = !rd_a[m_g];
            m_lba   = req_lba[32*m_g +: 32];
            m_busy  = 1'b1;
            m_c     = t;
            m_to    = ($urandom_range(0, 9) == 0);
            m_d     = $urandom_range(0, 3);
            m_len   = $urandom_range(1, 6);
            m_issue_end = m_to ? t + TOUT - 1 : t + m_d;
            m_done_at   = m_to ? t + TOUT     : t + m_d + m_len + 1;
         end
         m_idle_prev = !m_busy && !m_exp_done;

         exp_vec = (m_busy && t <= m_issue_end) ? oh(m_g) : 4'b0;
         chk("rnd_sd_rd", sd_rd, m_is_wr ? 4'b0 : exp_vec);
         chk("rnd_sd_wr", sd_wr, m_is_wr ? exp_vec : 4'b0);
         if (m_busy) chk("rnd_lba", sd_lba, m_lba);
         chk("rnd_ack",  req_ack,     (m_busy && ack_a) ? oh(m_g) : 4'b0);
         chk("rnd_bwr",  req_buff_wr, (m_busy && bwr_a) ? oh(m_g) : 4'b0);
         chk("rnd_bdin", sd_buff_din, m_busy ? din_a[8*m_g +: 8] : 8'h00);

         // drive next cycle
         sd_ack       = m_busy && !m_to && (t >= m_c + m_d) && (t < m_c + m_d + m_len);
         sd_buff_wr   = sd_ack && ($urandom_range(0, 1) == 1);
         req_buff_din = $urandom;
         if (m_exp_done) begin
            req_rd[m_g] = 1'b0;
            req_wr[m_g] = 1'b0;
         end
         for (int i = 0; i < VDNUM; i++) begin
            if (!(req_rd[i] | req_wr[i]) && !(m_exp_done && i == m_g) &&
                $urandom_range(0, 5) == 0) begin
               m_r = $urandom_range(0, 2);
               req_rd[i] = (m_r != 1);
               req_wr[i] = (m_r != 0);
               set_lba(i, $urandom);
            end
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
